pipelined_cpu: RTL and testbench
================================

// Module: pipelined_cpu
// PURPOSE
// - 5-stage in-order RV32I-subset pipeline: IF, ID, EX, MEM, WB. Top-level core of the design.
// - Contains the PC, instruction memory, register file, data memory, pipeline registers, hazard unit and forwarding unit.
// - Benches preload the memories and register file hierarchically, then run the core for a fixed cycle count.
// PARAMETERS
// - IMEM_WORDS  256  instruction memory depth (32-bit words), word index = PC[9:2]
// - DMEM_WORDS  32   data memory depth (32-bit words), word index = addr[6:2]
// PORTS
// - clk_i        in   1   clock, all state updates on rising edge
// - rst_i        in   1   synchronous reset, active high
// - start_i      in   1   run enable; 0 = PC holds (pipeline still drains)
// - pc_o         out  32  current fetch PC
// - stall_cnt_o  out  32  count of load-use stall cycles
// - flush_cnt_o  out  32  count of taken-branch flushes
// BEHAVIOUR
// - Reset: PC=0, counters=0, every IF/ID, ID/EX, EX/MEM and MEM/WB field=0 (bubble, no writes).
// - Reset clears nothing else: the imem, dmem and regfile arrays keep their contents. Named instr_mem, data_mem and regs.
// - ISA decode, by opcode/funct3/funct7:
//   - R-type 0110011: and(111), xor(100), sll(001, shift amount rs2[4:0]), add(000/0000000), sub(000/0100000), mul(000/0000001, low 32 bits).
//   - I-type 0010011: addi(000) uses a sign-extended imm. srai(101, imm[11:5]=0100000) is an arithmetic shift by imm[4:0].
//   - lw 0000011/010 and sw 0100011/010: address = rs1 + sext imm.
//   - beq 1100011/000: target = PC_ID + (sext B-imm << 1).
//   - Any other encoding (incl. all-zero word) = NOP: no reg/mem write.
// - IF: fetch instr_mem[PC>>2]. Next PC priority: stall hold > taken-branch target > PC+4. PC also holds while start_i=0.
// - ID: read regfile, generate the immediate, decode control signals.
//   - beq compares the raw regfile read data in ID; no forwarding into ID.
//   - Taken branch: PC<=target, and IF/ID is cleared to zero next edge (flush). flush_cnt_o += 1.
// - Load-use hazard: ID/EX.MemRead=1 and ID/EX.rd!=0 and rd equals the ID instruction's rs1 or rs2.
//   - Effect: PC and IF/ID hold, ID/EX gets a bubble (all control=0), 1-cycle penalty.
//   - stall_cnt_o += 1 only when the ID instruction is not a beq.
// - Stall and taken branch in the same cycle: the stall wins and the branch re-evaluates next cycle.
// - EX forwarding, per operand:
//   - EX/MEM.RegWrite, rd!=0 and rd==rs -> use EX/MEM ALU result (priority 1).
//   - Otherwise MEM/WB.RegWrite, rd!=0 and rd==rs -> use the WB write data (priority 2).
//   - Otherwise use the ID/EX register data. Forwarded rs2 is also the sw store data.
// - MEM: lw reads data_mem combinationally. sw writes on the clock edge. Word-aligned only; address bits [1:0] ignored.
// - WB: write data = MemtoReg ? load data : ALU result.
//   - Regfile write on the clock edge; writes to x0 ignored, x0 always reads 0.
//   - Regfile read bypasses a same-cycle WB write, so ID sees the new value.
// - Arithmetic wraps modulo 2^32; no overflow traps.
// - Out-of-range addresses use the low index bits (wrap-around).
// CONFIGURATION
// - CPU_MUL_EN defined: mul executes as specified.
// - CPU_MUL_EN undefined: the mul encoding decodes as a NOP (no regfile write). No multiplier is synthesized.
// TESTING
// - Reset/idle: rst_i=1 for 1 edge, all-zero imem -> pc_o steps 0,4,8,...; regs unchanged; counters stay 0.
// - ALU + forwarding: addi x1,x0,5; addi x2,x1,3; sub x3,x2,x1; mul x4,x2,x2 -> x1=5, x2=8, x3=3, x4=64. No stalls.
// - Load-use: dmem[0]=5; lw x1,0(x0); add x2,x1,x1 -> x2=10, stall_cnt_o=1.
// - Store: addi x5,x0,-7; sw x5,8(x0) -> data_mem[2]=0xFFFFFFF9. Then srai x6,x5,1 -> x6=-4.
// - Branch: beq x0,x0,+8 with the next instr addi x7,x0,1 -> x7 stays 0, flush_cnt_o=1, PC skips by 8.
// - start_i=0 with reset released -> pc_o frozen at 0; raising start_i resumes fetch.

Source files
------------

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 5-stage in-order RV32I-subset core (IF, ID, EX, MEM, WB).
// Holds the PC, instruction memory, register file, data memory, pipeline
// registers, load-use hazard detection and EX-stage operand forwarding.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   synchronous reset, active high
//   start_i      in   1   run enable; 0 holds the PC while the pipeline drains
//   pc_o         out  32  current fetch PC
//   stall_cnt_o  out  32  load-use stall cycles (beq in ID not counted)
//   flush_cnt_o  out  32  taken-branch flushes
//
// Configuration macro: CPU_MUL_EN. When defined, the mul encoding executes;
// when undefined it decodes as a NOP and no multiplier exists.
//
// Memory arrays instr_mem, data_mem and regs are not cleared by reset.
module pipelined_cpu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] pc_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned IMEM_WORDS = 256;
  localparam int unsigned DMEM_WORDS = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
`ifdef CPU_MUL_EN
  localparam logic [6:0] F7_MUL     = 7'b0000001;
`endif

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_e;

  // Storage
  logic [31:0] instr_mem [IMEM_WORDS];
  logic [31:0] data_mem  [DMEM_WORDS];
  logic [31:0] regs      [NUM_REGS];

  // Architectural / pipeline state
  logic [31:0] pc_q;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  logic [31:0] ifid_instr, ifid_pc;

  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg;
  logic        idex_alu_src;
  alu_op_e     idex_alu_op;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [31:0] idex_rd1, idex_rd2, idex_imm;

  logic        exmem_reg_write, exmem_mem_write, exmem_mem_to_reg;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu, exmem_store;

  logic        memwb_reg_write, memwb_mem_to_reg;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_alu, memwb_load;

  // Combinational signals
  logic [31:0] if_instr;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] id_rd1, id_rd2;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic        dec_alu_src, dec_is_beq;
  alu_op_e     dec_alu_op;
  logic [31:0] dec_imm;
  logic        load_use, br_taken;
  logic [31:0] br_target;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
  logic [31:0] mem_load, wb_data;

  assign pc_o        = pc_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // ---------------- IF ----------------
  assign if_instr = instr_mem[pc_q[9:2]];

  // Stall hold beats a branch redirect; start_i only stops sequential fetch
  always_ff @(posedge clk_i) begin
    if (rst_i)         pc_q <= '0;
    else if (load_use) pc_q <= pc_q;
    else if (br_taken) pc_q <= br_target;
    else if (start_i)  pc_q <= pc_q + 32'd4;
  end

  // IF/ID: hold on stall, bubble on flush or while fetch is paused
  always_ff @(posedge clk_i) begin
    if (rst_i || (!load_use && (br_taken || !start_i))) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (!load_use) begin
      ifid_instr <= if_instr;
      ifid_pc    <= pc_q;
    end
  end

  // ---------------- ID ----------------
  assign id_opcode = ifid_instr[6:0];
  assign id_rd     = ifid_instr[11:7];
  assign id_funct3 = ifid_instr[14:12];
  assign id_rs1    = ifid_instr[19:15];
  assign id_rs2    = ifid_instr[24:20];
  assign id_funct7 = ifid_instr[31:25];

  assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                  ifid_instr[30:25], ifid_instr[11:8], 1'b0};

  // Register read; a same-cycle WB write is visible, x0 reads zero
  always_comb begin
    id_rd1 = regs[id_rs1];
    id_rd2 = regs[id_rs2];
    if (id_rs1 == 5'd0)                                    id_rd1 = '0;
    else if (memwb_reg_write && (memwb_rd == id_rs1))      id_rd1 = wb_data;
    if (id_rs2 == 5'd0)                                    id_rd2 = '0;
    else if (memwb_reg_write && (memwb_rd == id_rs2))      id_rd2 = wb_data;
  end

  // Instruction decode; unrecognised encodings fall through as NOPs
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_is_beq     = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_imm        = imm_i;
    case (id_opcode)
      OPC_R: begin
        dec_reg_write = 1'b1;
        case ({id_funct7, id_funct3})
          {F7_BASE, 3'b000}: dec_alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: dec_alu_op = ALU_SUB;
          {F7_BASE, 3'b111}: dec_alu_op = ALU_AND;
          {F7_BASE, 3'b100}: dec_alu_op = ALU_XOR;
          {F7_BASE, 3'b001}: dec_alu_op = ALU_SLL;
`ifdef CPU_MUL_EN
          {F7_MUL,  3'b000}: dec_alu_op = ALU_MUL;
`endif
          default:           dec_reg_write = 1'b0;
        endcase
      end
      OPC_I: begin
        dec_alu_src = 1'b1;
        if (id_funct3 == 3'b000) begin
          dec_reg_write = 1'b1;
        end else if ((id_funct3 == 3'b101) && (id_funct7 == F7_ALT)) begin
          dec_reg_write = 1'b1;
          dec_alu_op    = ALU_SRA;
        end
      end
      OPC_LOAD: begin
        if (id_funct3 == 3'b010) begin
          dec_reg_write  = 1'b1;
          dec_mem_read   = 1'b1;
          dec_mem_to_reg = 1'b1;
          dec_alu_src    = 1'b1;
        end
      end
      OPC_STORE: begin
        if (id_funct3 == 3'b010) begin
          dec_mem_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_imm       = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (id_funct3 == 3'b000) dec_is_beq = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use uses raw rs fields; branch compares unforwarded register data
  assign load_use  = idex_mem_read && (idex_rd != 5'd0) &&
                     ((idex_rd == id_rs1) || (idex_rd == id_rs2));
  assign br_taken  = dec_is_beq && (id_rd1 == id_rd2) && !load_use;
  assign br_target = ifid_pc + imm_b;

  // ID/EX: bubble on stall
  always_ff @(posedge clk_i) begin
    if (rst_i || load_use) begin
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_alu_op     <= ALU_ADD;
      idex_rs1        <= '0;
      idex_rs2        <= '0;
      idex_rd         <= '0;
      idex_rd1        <= '0;
      idex_rd2        <= '0;
      idex_imm        <= '0;
    end else begin
      idex_reg_write  <= dec_reg_write;
      idex_mem_read   <= dec_mem_read;
      idex_mem_write  <= dec_mem_write;
      idex_mem_to_reg <= dec_mem_to_reg;
      idex_alu_src    <= dec_alu_src;
      idex_alu_op     <= dec_alu_op;
      idex_rs1        <= id_rs1;
      idex_rs2        <= id_rs2;
      idex_rd         <= id_rd;
      idex_rd1        <= id_rd1;
      idex_rd2        <= id_rd2;
      idex_imm        <= dec_imm;
    end
  end

  // ---------------- EX ----------------
  // Forwarding: EX/MEM result first, then the WB write data
  always_comb begin
    fwd_a = idex_rd1;
    fwd_b = idex_rd2;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == idex_rs1))
      fwd_a = exmem_alu;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == idex_rs1))
      fwd_a = wb_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == idex_rs2))
      fwd_b = exmem_alu;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == idex_rs2))
      fwd_b = wb_data;
  end

  assign alu_b = idex_alu_src ? idex_imm : fwd_b;

  always_comb begin
    alu_y = '0;
    case (idex_alu_op)
      ALU_ADD: alu_y = fwd_a + alu_b;
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_XOR: alu_y = fwd_a ^ alu_b;
      ALU_SLL: alu_y = fwd_a << alu_b[4:0];
      ALU_SRA: alu_y = 32'($signed(fwd_a) >>> alu_b[4:0]);
`ifdef CPU_MUL_EN
      ALU_MUL: alu_y = fwd_a * alu_b;
`endif
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_reg_write  <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_rd         <= '0;
      exmem_alu        <= '0;
      exmem_store      <= '0;
    end else begin
      exmem_reg_write  <= idex_reg_write;
      exmem_mem_write  <= idex_mem_write;
      exmem_mem_to_reg <= idex_mem_to_reg;
      exmem_rd         <= idex_rd;
      exmem_alu        <= alu_y;
      exmem_store      <= fwd_b;
    end
  end

  // ---------------- MEM ----------------
  assign mem_load = data_mem[exmem_alu[6:2]];

  always_ff @(posedge clk_i) begin
    if (exmem_mem_write) data_mem[exmem_alu[6:2]] <= exmem_store;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_rd         <= '0;
      memwb_alu        <= '0;
      memwb_load       <= '0;
    end else begin
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_rd         <= exmem_rd;
      memwb_alu        <= exmem_alu;
      memwb_load       <= mem_load;
    end
  end

  // ---------------- WB ----------------
  assign wb_data = memwb_mem_to_reg ? memwb_load : memwb_alu;

  always_ff @(posedge clk_i) begin
    if (memwb_reg_write && (memwb_rd != 5'd0)) regs[memwb_rd] <= wb_data;
  end

  // Performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use && !dec_is_beq) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_taken)                flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipelined_cpu.sv
// tb_pipelined_cpu: directed spec scenarios plus random programs checked
// against an instruction-level reference interpreter.
module tb_pipelined_cpu;

  logic        clk_i, rst_i, start_i;
  logic [31:0] pc_o, stall_cnt_o, flush_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] init_regs [32];
  logic [31:0] init_dmem [32];
  logic [31:0] m_regs    [32];
  logic [31:0] m_dmem    [32];
  logic [31:0] prog [$];
  logic [31:0] exp_stall, exp_flush;

  pipelined_cpu dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_o        (pc_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] beq_i(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 12))
      0:  return r_type(7'h00, rs2, rs1, 3'b000, rd);
      1:  return r_type(7'h20, rs2, rs1, 3'b000, rd);
      2:  return r_type(7'h00, rs2, rs1, 3'b111, rd);
      3:  return r_type(7'h00, rs2, rs1, 3'b100, rd);
      4:  return r_type(7'h00, rs2, rs1, 3'b001, rd);
      5:  return r_type(7'h01, rs2, rs1, 3'b000, rd);
      6:  return i_type(imm, rs1, 3'b000, rd, 7'b0010011);
      7:  return i_type({7'h20, rs2}, rs1, 3'b101, rd, 7'b0010011);
      8, 9:   return i_type(imm, rs1, 3'b010, rd, 7'b0000011);
      10: return s_type(imm, rs2, rs1);
      11: return 32'h0;
      default: return r_type(7'h01, rs2, rs1, 3'b100, rd);
    endcase
  endfunction

  // Groups of: 3 random, nop, nop, beq, 2 random. Branch lands on a non-beq,
  // and the two nops keep the unforwarded beq operands architecturally current.
  task automatic gen_prog(input int groups);
    logic [4:0]  r1, r2;
    logic [12:0] off;
    prog.delete();
    for (int g = 0; g < groups; g++) begin
      repeat (3) prog.push_back(rand_instr());
      r1  = 5'($urandom_range(0, 7));
      r2  = ($urandom_range(0, 1) == 1) ? r1 : 5'($urandom_range(0, 7));
      off = ($urandom_range(0, 1) == 1) ? 13'd8 : 13'd12;
      prog.push_back(32'h0);
      prog.push_back(32'h0);
      prog.push_back(beq_i(r1, r2, off));
      repeat (2) prog.push_back(rand_instr());
    end
  endtask

  // ---------------- reference model ----------------
  // Executes the program in order; stalls counted from adjacent dynamic pairs.
  task automatic model_run();
    logic [31:0] pc, ins, a, b, r, addr, nxt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2, prev_rd;
    logic        wr, prev_lw, is_beq;
    m_regs = init_regs;
    m_dmem = init_dmem;
    exp_stall = 0;
    exp_flush = 0;
    pc = 0;
    prev_lw = 1'b0;
    prev_rd = 5'd0;
    while ((pc >> 2) < 32'(prog.size())) begin
      ins = prog[pc >> 2];
      opc = ins[6:0];  rd = ins[11:7];  f3 = ins[14:12];
      rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
      is_beq = (opc == 7'b1100011) && (f3 == 3'b000);
      if (prev_lw && prev_rd != 5'd0 && (prev_rd == rs1 || prev_rd == rs2) && !is_beq)
        exp_stall++;
      a = m_regs[rs1];
      b = m_regs[rs2];
      wr = 1'b0; r = 0; nxt = pc + 4; prev_lw = 1'b0;
      case (opc)
        7'b0110011: begin
          wr = 1'b1;
          if      (f7 == 7'h00 && f3 == 3'b000) r = a + b;
          else if (f7 == 7'h20 && f3 == 3'b000) r = a - b;
          else if (f7 == 7'h00 && f3 == 3'b111) r = a & b;
          else if (f7 == 7'h00 && f3 == 3'b100) r = a ^ b;
          else if (f7 == 7'h00 && f3 == 3'b001) r = a << b[4:0];
`ifdef CPU_MUL_EN
          else if (f7 == 7'h01 && f3 == 3'b000) r = a * b;
`endif
          else wr = 1'b0;
        end
        7'b0010011: begin
          if (f3 == 3'b000) begin
            wr = 1'b1; r = a + {{20{ins[31]}}, ins[31:20]};
          end else if (f3 == 3'b101 && f7 == 7'h20) begin
            wr = 1'b1; r = 32'($signed(a) >>> ins[24:20]);
          end
        end
        7'b0000011: if (f3 == 3'b010) begin
          addr = a + {{20{ins[31]}}, ins[31:20]};
          r = m_dmem[addr[6:2]]; wr = 1'b1; prev_lw = 1'b1;
        end
        7'b0100011: if (f3 == 3'b010) begin
          addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
          m_dmem[addr[6:2]] = b;
        end
        7'b1100011: if (is_beq && a == b) begin
          nxt = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
          exp_flush++;
        end
        default: ;
      endcase
      if (wr && rd != 5'd0) m_regs[rd] = r;
      prev_rd = rd;
      pc = nxt;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic clear_init();
    for (int i = 0; i < 32; i++) begin
      init_regs[i] = 0;
      init_dmem[i] = 0;
    end
  endtask

  task automatic do_reset(input logic st);
    rst_i   = 1'b1;
    start_i = st;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 256; i++)
      dut.instr_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    for (int i = 0; i < 32; i++) begin
      dut.regs[i]     = init_regs[i];
      dut.data_mem[i] = init_dmem[i];
    end
    rst_i = 1'b0;
  endtask

  task automatic compare_state(input string tag);
    model_run();
    for (int i = 1; i < 32; i++)
      check_eq($sformatf("%s x%0d", tag, i), dut.regs[i], m_regs[i]);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s dmem[%0d]", tag, i), dut.data_mem[i], m_dmem[i]);
    check_eq({tag, " stall_cnt"}, stall_cnt_o, exp_stall);
    check_eq({tag, " flush_cnt"}, flush_cnt_o, exp_flush);
  endtask

  task automatic run_directed(input string tag, input int cycles);
    do_reset(1'b1);
    repeat (cycles) @(negedge clk_i);
    compare_state(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;

    // Reset and idle fetch over an all-zero imem
    prog.delete();
    clear_init();
    for (int i = 1; i < 32; i++) init_regs[i] = $urandom;
    do_reset(1'b1);
    check_eq("reset pc", pc_o, 32'h0);
    check_eq("reset stall_cnt", stall_cnt_o, 32'h0);
    check_eq("reset flush_cnt", flush_cnt_o, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      check_eq($sformatf("idle pc step %0d", k), pc_o, 32'(4 * k));
    end
    compare_state("idle");

    // start_i low freezes fetch; raising it resumes
    do_reset(1'b0);
    repeat (4) @(negedge clk_i);
    check_eq("paused pc", pc_o, 32'h0);
    start_i = 1'b1;
    @(negedge clk_i);
    check_eq("resumed pc", pc_o, 32'h4);

    // ALU + forwarding
    clear_init();
    prog.delete();
    prog.push_back(i_type(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    prog.push_back(i_type(12'd3, 5'd1, 3'b000, 5'd2, 7'b0010011));
    prog.push_back(r_type(7'h20, 5'd1, 5'd2, 3'b000, 5'd3));
    prog.push_back(r_type(7'h01, 5'd2, 5'd2, 3'b000, 5'd4));
    run_directed("alu", 20);
    check_eq("alu x1", dut.regs[1], 32'd5);
    check_eq("alu x2", dut.regs[2], 32'd8);
    check_eq("alu x3", dut.regs[3], 32'd3);
`ifdef CPU_MUL_EN
    check_eq("alu mul x4", dut.regs[4], 32'd64);
`else
    check_eq("alu mul-disabled x4", dut.regs[4], 32'd0);
`endif
    check_eq("alu no stall", stall_cnt_o, 32'd0);

    // Load-use stall
    clear_init();
    init_dmem[0] = 32'd5;
    prog.delete();
    prog.push_back(i_type(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011));
    prog.push_back(r_type(7'h00, 5'd1, 5'd1, 3'b000, 5'd2));
    run_directed("loaduse", 20);
    check_eq("loaduse x2", dut.regs[2], 32'd10);
    check_eq("loaduse stall_cnt", stall_cnt_o, 32'd1);

    // Store with forwarded data, then arithmetic shift
    clear_init();
    prog.delete();
    prog.push_back(i_type(12'hFF9, 5'd0, 3'b000, 5'd5, 7'b0010011));
    prog.push_back(s_type(12'd8, 5'd5, 5'd0));
    prog.push_back(i_type({7'h20, 5'd1}, 5'd5, 3'b101, 5'd6, 7'b0010011));
    run_directed("store", 20);
    check_eq("store dmem[2]", dut.data_mem[2], 32'hFFFF_FFF9);
    check_eq("srai x6", dut.regs[6], 32'hFFFF_FFFC);

    // Taken branch flushes the shadow instruction
    clear_init();
    prog.delete();
    prog.push_back(beq_i(5'd0, 5'd0, 13'd8));
    prog.push_back(i_type(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011));
    prog.push_back(i_type(12'd9, 5'd0, 3'b000, 5'd8, 7'b0010011));
    do_reset(1'b1);
    @(negedge clk_i);
    check_eq("branch pc fetch", pc_o, 32'd4);
    @(negedge clk_i);
    check_eq("branch pc target", pc_o, 32'd8);
    @(negedge clk_i);
    check_eq("branch pc after", pc_o, 32'd12);
    repeat (15) @(negedge clk_i);
    check_eq("branch x7", dut.regs[7], 32'd0);
    check_eq("branch x8", dut.regs[8], 32'd9);
    check_eq("branch flush_cnt", flush_cnt_o, 32'd1);
    compare_state("branch");

    // Random programs against the reference interpreter
    for (int t = 0; t < 20; t++) begin
      init_regs[0] = 0;
      for (int i = 1; i < 32; i++)
        init_regs[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      for (int i = 0; i < 32; i++) init_dmem[i] = $urandom;
      gen_prog(8);
      run_directed($sformatf("rand%0d", t), 2 * prog.size() + 12);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
